// File: rtl/wifi_tx_pkg.sv
// Shared definitions for the 802.11a/g transmit bit path: frame sequencer states
// and the fixed field lengths of the DATA field.
package wifi_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLR     = 3'd1,
    S_SERVICE = 3'd2,
    S_DATA    = 3'd3,
    S_TAIL    = 3'd4,
    S_PAD     = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  localparam int SERVICE_BITS = 16;
  localparam int TAIL_BITS    = 6;
  localparam int NDBPS_MIN    = 24;
  localparam int NDBPS_MAX    = 216;

  // States that emit a locally generated zero every cycle without stalling.
  function automatic logic issues_zero(input state_e s);
    case (s)
      S_SERVICE, S_TAIL, S_PAD: issues_zero = 1'b1;
      default:                  issues_zero = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/conv_enc_frame_ctrl_if.sv
// Bit-serial PSDU stream from the scrambler into the frame sequencer.
interface conv_enc_frame_ctrl_if;
  logic data_bit;
  logic data_valid;
  logic data_ready;

  modport master (output data_bit, output data_valid, input  data_ready);
  modport slave  (input  data_bit, input  data_valid, output data_ready);
endinterface

// File: rtl/conv_enc_frame_ctrl.sv
// Sequences one DATA field (SERVICE, PSDU, tail, pad) into the rate-1/2
// convolutional encoder and marks the last bit of every OFDM symbol.
module conv_enc_frame_ctrl
  import wifi_tx_pkg::*;
#(
  parameter int LEN_W   = 12,
  parameter int NDBPS_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len_bytes,
  input  logic [NDBPS_W-1:0]   n_dbps,
  output logic                 busy,
  output logic                 done,
  conv_enc_frame_ctrl_if.slave up,
  output logic                 enc_bit,
  output logic                 enc_valid,
  output logic                 enc_clr,
  output logic                 sym_last
);

  localparam int FIELD_W = LEN_W + 3;
  localparam logic [NDBPS_W-1:0] L_NDBPS_MIN    = NDBPS_W'(NDBPS_MIN);
  localparam logic [NDBPS_W-1:0] L_NDBPS_MAX    = NDBPS_W'(NDBPS_MAX);
  localparam logic [NDBPS_W-1:0] L_SYM_ONE      = NDBPS_W'(1);
  localparam logic [FIELD_W-1:0] L_FIELD_ONE    = FIELD_W'(1);
  localparam logic [FIELD_W-1:0] L_SERVICE_LAST = FIELD_W'(SERVICE_BITS - 1);
  localparam logic [FIELD_W-1:0] L_TAIL_LAST    = FIELD_W'(TAIL_BITS - 1);

  state_e               r_state;
  logic [LEN_W-1:0]     r_len;
  logic [NDBPS_W-1:0]   r_ndbps;
  logic [FIELD_W-1:0]   r_field_cnt;
  logic [NDBPS_W-1:0]   r_sym_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_enc_bit;
  logic                 r_enc_valid;
  logic                 r_enc_clr;
  logic                 r_sym_last;

  logic                 w_issue;
  logic                 w_bit;
  logic                 w_sym_wrap;
  logic                 w_data_last;
  logic [NDBPS_W-1:0]   w_sym_next;
  logic [NDBPS_W-1:0]   w_ndbps_clamped;

  assign up.data_ready = (r_state == S_DATA);

  // A bit is issued every cycle in the zero-fill states, only on a transfer in DATA.
  always_comb begin
    w_issue = 1'b0;
    w_bit   = 1'b0;
    if (issues_zero(r_state)) begin
      w_issue = 1'b1;
      w_bit   = 1'b0;
    end else if (r_state == S_DATA) begin
      w_issue = up.data_valid;
      w_bit   = up.data_valid & up.data_bit;
    end else begin
      w_issue = 1'b0;
      w_bit   = 1'b0;
    end
  end

  // Symbol position, end-of-PSDU detect and n_dbps clamping.
  always_comb begin
    w_sym_wrap      = (r_sym_cnt == (r_ndbps - L_SYM_ONE));
    w_sym_next      = '0;
    w_data_last     = (r_field_cnt == ({r_len, 3'b000} - L_FIELD_ONE));
    w_ndbps_clamped = n_dbps;
    if (w_sym_wrap) begin
      w_sym_next = '0;
    end else begin
      w_sym_next = r_sym_cnt + L_SYM_ONE;
    end
    if (n_dbps < L_NDBPS_MIN) begin
      w_ndbps_clamped = L_NDBPS_MIN;
    end else if (n_dbps > L_NDBPS_MAX) begin
      w_ndbps_clamped = L_NDBPS_MAX;
    end else begin
      w_ndbps_clamped = n_dbps;
    end
  end

  // Frame FSM with counters and registered encoder-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_ndbps     <= '0;
      r_field_cnt <= '0;
      r_sym_cnt   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_enc_bit   <= 1'b0;
      r_enc_valid <= 1'b0;
      r_enc_clr   <= 1'b0;
      r_sym_last  <= 1'b0;
    end else begin
      r_enc_clr   <= 1'b0;
      r_done      <= 1'b0;
      r_enc_valid <= w_issue;
      r_enc_bit   <= w_bit;
      r_sym_last  <= w_issue & w_sym_wrap;
      if (w_issue) begin
        r_sym_cnt <= w_sym_next;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len       <= len_bytes;
            r_ndbps     <= w_ndbps_clamped;
            r_busy      <= 1'b1;
            r_enc_clr   <= 1'b1;
            r_field_cnt <= '0;
            r_state     <= S_CLR;
          end
        end
        S_CLR: begin
          r_sym_cnt   <= '0;
          r_field_cnt <= '0;
          r_state     <= S_SERVICE;
        end
        S_SERVICE: begin
          if (r_field_cnt == L_SERVICE_LAST) begin
            r_field_cnt <= '0;
            r_state     <= (r_len == '0) ? S_TAIL : S_DATA;
          end else begin
            r_field_cnt <= r_field_cnt + L_FIELD_ONE;
          end
        end
        S_DATA: begin
          if (up.data_valid) begin
            if (w_data_last) begin
              r_field_cnt <= '0;
              r_state     <= S_TAIL;
            end else begin
              r_field_cnt <= r_field_cnt + L_FIELD_ONE;
            end
          end
        end
        S_TAIL: begin
          // Skip padding when the sixth tail bit already closes a symbol.
          if (r_field_cnt == L_TAIL_LAST) begin
            r_field_cnt <= '0;
            r_state     <= (w_sym_next == '0) ? S_DONE : S_PAD;
          end else begin
            r_field_cnt <= r_field_cnt + L_FIELD_ONE;
          end
        end
        S_PAD: begin
          if (w_sym_wrap) begin
            r_field_cnt <= '0;
            r_state     <= S_DONE;
          end else begin
            r_field_cnt <= r_field_cnt + L_FIELD_ONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign enc_bit   = r_enc_bit;
  assign enc_valid = r_enc_valid;
  assign enc_clr   = r_enc_clr;
  assign sym_last  = r_sym_last;

endmodule

// File: tb/tb_conv_enc_frame_ctrl.sv
// Self-checking bench for conv_enc_frame_ctrl: scoreboarded bit stream, symbol
// marking, done/busy timing, stalls, ignored starts, clamping and reset abort.
module tb_conv_enc_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] len_bytes;
  logic [7:0]  n_dbps;
  logic        busy, done, enc_bit, enc_valid, enc_clr, sym_last;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] frame_bytes [16];

  always #5 clk = ~clk;

  conv_enc_frame_ctrl_if up_if ();

  conv_enc_frame_ctrl #(.LEN_W(12), .NDBPS_W(8)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .start     (start),
    .len_bytes (len_bytes),
    .n_dbps    (n_dbps),
    .busy      (busy),
    .done      (done),
    .up        (up_if),
    .enc_bit   (enc_bit),
    .enc_valid (enc_valid),
    .enc_clr   (enc_clr),
    .sym_last  (sym_last)
  );

  // Runs one frame from start to done; expected bits are queued up front and popped per enc_valid.
  task automatic run_frame(input string tag, input int len, input int nd, input int exp_total,
                           input int stall_at, input int stall_len, input int busy_start_at);
    bit   exp_q[$];
    int   n_eff, cyc, bit_idx, stall_left, outcnt, clr_cnt, gaps, last_valid, budget;
    bit   done_seen, consumed, eb;
    logic exp_sl;
    n_eff = (nd < 24) ? 24 : ((nd > 216) ? 216 : nd);
    for (int i = 0; i < 16; i++) exp_q.push_back(1'b0);
    for (int i = 0; i < len; i++)
      for (int b = 0; b < 8; b++) exp_q.push_back(frame_bytes[i][b]);
    for (int i = 0; i < 6; i++) exp_q.push_back(1'b0);
    while ((exp_q.size() % n_eff) != 0) exp_q.push_back(1'b0);
    cyc = 0; bit_idx = 0; stall_left = stall_len; outcnt = 0; clr_cnt = 0; gaps = 0;
    last_valid = -10; done_seen = 1'b0; consumed = 1'b0;
    budget = 4 * exp_total + 64;
    start = 1'b1; len_bytes = len[11:0]; n_dbps = nd[7:0];
    up_if.data_valid = 1'b0; up_if.data_bit = 1'b0;
    while (!done_seen && cyc < budget) begin
      @(posedge clk); #1; cyc++;
      if (consumed) bit_idx++;
      if (enc_clr) begin
        clr_cnt++; n_checks++;
        if (outcnt !== 0) begin
          n_fail++; $display("FAIL %s clr_order: enc_clr after %0d bits, required 0", tag, outcnt);
        end
      end
      if (enc_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL %s extra_bit: bit %0d issued, required only %0d", tag, outcnt + 1, exp_total);
        end else begin
          eb = exp_q.pop_front();
          if (enc_bit !== eb) begin
            n_fail++; $display("FAIL %s enc_bit[%0d]: got %b required %b", tag, outcnt + 1, enc_bit, eb);
          end
        end
        exp_sl = (((outcnt + 1) % n_eff) == 0);
        n_checks++;
        if (sym_last !== exp_sl) begin
          n_fail++; $display("FAIL %s sym_last[%0d]: got %b required %b", tag, outcnt + 1, sym_last, exp_sl);
        end
        outcnt++; last_valid = cyc;
      end else begin
        n_checks++;
        if (enc_bit !== 1'b0 || sym_last !== 1'b0) begin
          n_fail++; $display("FAIL %s idle_bits: enc_bit=%b sym_last=%b required 0/0", tag, enc_bit, sym_last);
        end
        if (outcnt > 0 && outcnt < exp_total) gaps++;
      end
      n_checks++;
      if (done) begin
        done_seen = 1'b1;
        if (last_valid !== cyc - 1) begin
          n_fail++; $display("FAIL %s done_timing: last bit at cycle %0d, done at %0d, required 1 apart", tag, last_valid, cyc);
        end
      end else if (busy !== 1'b1) begin
        n_fail++; $display("FAIL %s busy: got %b at cycle %0d required 1", tag, busy, cyc);
      end
      start = (cyc == busy_start_at);
      if (start) begin
        len_bytes = 12'd5; n_dbps = 8'd100;
      end
      if (up_if.data_ready && bit_idx == stall_at && stall_left > 0) begin
        up_if.data_valid = 1'b0; stall_left--;
      end else if (bit_idx < 8 * len) begin
        up_if.data_valid = 1'b1; up_if.data_bit = frame_bytes[bit_idx / 8][bit_idx % 8];
      end else begin
        up_if.data_valid = 1'b0; up_if.data_bit = 1'b0;
      end
      consumed = up_if.data_ready && up_if.data_valid;
    end
    start = 1'b0; up_if.data_valid = 1'b0; up_if.data_bit = 1'b0;
    n_checks++;
    if (!done_seen) begin
      n_fail++; $display("FAIL %s timeout: no done within %0d cycles", tag, budget);
    end
    n_checks++;
    if (outcnt !== exp_total) begin
      n_fail++; $display("FAIL %s bit_count: got %0d required %0d", tag, outcnt, exp_total);
    end
    n_checks++;
    if (clr_cnt !== 1) begin
      n_fail++; $display("FAIL %s clr_count: got %0d required 1", tag, clr_cnt);
    end
    n_checks++;
    if (gaps !== stall_len) begin
      n_fail++; $display("FAIL %s stall_gaps: got %0d required %0d", tag, gaps, stall_len);
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL %s missing_bits: %0d bits never issued, required 0", tag, exp_q.size());
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s after_done: done=%b busy=%b required 0/0", tag, done, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; len_bytes = 12'd0; n_dbps = 8'd0;
    up_if.data_valid = 1'b0; up_if.data_bit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, enc_bit, enc_valid, enc_clr, sym_last, up_if.data_ready} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b required 0000000",
                         {busy, done, enc_bit, enc_valid, enc_clr, sym_last, up_if.data_ready});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done, enc_valid, enc_clr} !== 4'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b required 0000", {busy, done, enc_valid, enc_clr});
    end
  endtask

  task automatic test_len0();
    run_frame("len0_nd24", 0, 24, 24, -1, 0, -1);
  endtask

  task automatic test_stream();
    frame_bytes[0] = 8'hA5; frame_bytes[1] = 8'h0F; frame_bytes[2] = 8'hFF;
    run_frame("len3_nd48", 3, 48, 48, -1, 0, -1);
  endtask

  task automatic test_no_pad();
    frame_bytes[0] = 8'($urandom);
    run_frame("len1_nd30", 1, 30, 30, -1, 0, -1);
  endtask

  task automatic test_stall();
    frame_bytes[0] = 8'h3C; frame_bytes[1] = 8'h96;
    run_frame("stall_len2_nd24", 2, 24, 48, 5, 5, -1);
  endtask

  task automatic test_start_while_busy();
    frame_bytes[0] = 8'($urandom); frame_bytes[1] = 8'($urandom);
    run_frame("busy_start", 2, 40, 40, -1, 0, 10);
  endtask

  task automatic test_clamp();
    frame_bytes[0] = 8'h5A;
    run_frame("clamp_low", 1, 10, 48, -1, 0, -1);
    frame_bytes[0] = 8'hC3;
    run_frame("clamp_high", 1, 250, 216, -1, 0, -1);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) frame_bytes[k] = 8'($urandom);
    run_frame("b2b_first", 3, 24, 48, -1, 0, -1);
    run_frame("b2b_second", 1, 24, 48, -1, 0, -1);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) frame_bytes[k] = 8'($urandom);
    start = 1'b1; len_bytes = 12'd4; n_dbps = 8'd48;
    up_if.data_valid = 1'b1; up_if.data_bit = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      up_if.data_bit = 1'($urandom);
    end
    n_checks++;
    if (up_if.data_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_in_data: data_ready=%b required 1", up_if.data_ready);
    end
    rst_n = 1'b0;
    up_if.data_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({busy, done, enc_bit, enc_valid, enc_clr, sym_last, up_if.data_ready} !== 7'b0) begin
        n_fail++; $display("FAIL reset_mid_outputs: got %b required 0000000",
                           {busy, done, enc_bit, enc_valid, enc_clr, sym_last, up_if.data_ready});
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    frame_bytes[0] = 8'h81; frame_bytes[1] = 8'h7E;
    run_frame("after_reset", 2, 24, 48, -1, 0, -1);
  endtask

  initial begin
    test_reset();
    test_len0();
    test_stream();
    test_no_pad();
    test_stall();
    test_start_while_busy();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
